// File: rtl/otter_id_ex_stage.sv
// ID/EX pipeline register of the pipelined OTTER core: captures decoded fields,
// forwards MEM/WB results into the ALU operands and detects load-use hazards.
module otter_id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ID_VALID,
  input  logic [XLEN-1:0] ID_PC,
  input  logic [4:0]      ID_RS1_ADDR,
  input  logic [4:0]      ID_RS2_ADDR,
  input  logic [4:0]      ID_RD_ADDR,
  input  logic [XLEN-1:0] ID_RS1_DATA,
  input  logic [XLEN-1:0] ID_RS2_DATA,
  input  logic [XLEN-1:0] ID_IMM,
  input  logic [3:0]      ID_ALU_FUN,
  input  logic [1:0]      ID_SRCA_SEL,
  input  logic            ID_SRCB_SEL,
  input  logic            ID_REG_WRITE,
  input  logic            ID_MEM_READ,
  input  logic            ID_MEM_WRITE,
  input  logic            FLUSH,
  input  logic [4:0]      MEM_RD_ADDR,
  input  logic            MEM_REG_WRITE,
  input  logic [XLEN-1:0] MEM_ALU_RESULT,
  input  logic [4:0]      WB_RD_ADDR,
  input  logic            WB_REG_WRITE,
  input  logic [XLEN-1:0] WB_DATA,
  output logic            ID_STALL,
  output logic            EX_VALID,
  output logic [XLEN-1:0] ALU_A,
  output logic [XLEN-1:0] ALU_B,
  output logic [3:0]      ALU_FUN,
  output logic [XLEN-1:0] EX_RS2_DATA,
  output logic [XLEN-1:0] EX_PC,
  output logic [4:0]      EX_RD_ADDR,
  output logic            EX_REG_WRITE,
  output logic            EX_MEM_READ,
  output logic            EX_MEM_WRITE
);

  localparam logic [1:0] SRCA_RS1  = 2'd0;
  localparam logic [1:0] SRCA_IMM  = 2'd1;
  localparam logic [1:0] SRCA_PC   = 2'd2;
  localparam logic [1:0] SRCA_RSV  = 2'd3;

  logic            ex_valid_reg;
  logic [XLEN-1:0] ex_pc_reg;
  logic [4:0]      ex_rd_addr_reg;
  logic            ex_reg_write_reg;
  logic            ex_mem_read_reg;
  logic            ex_mem_write_reg;
  logic [3:0]      alu_fun_reg;
  logic [XLEN-1:0] imm_reg;
  logic [1:0]      srca_sel_reg;
  logic            srcb_sel_reg;

  // Index 0 is rs1, index 1 is rs2; both operand paths are identical.
  logic [4:0]      id_src_addr   [2];
  logic [XLEN-1:0] id_src_data   [2];
  logic [XLEN-1:0] src_capture   [2];
  logic [4:0]      src_addr_reg  [2];
  logic [XLEN-1:0] src_data_reg  [2];
  logic [XLEN-1:0] src_fwd       [2];

  logic rs1_used;
  logic rs2_used;
  logic load_use;
  logic load_bubble;

  assign id_src_addr[0] = ID_RS1_ADDR;
  assign id_src_addr[1] = ID_RS2_ADDR;
  assign id_src_data[0] = ID_RS1_DATA;
  assign id_src_data[1] = ID_RS2_DATA;

  // Load-use detection against the instruction currently in EX.
  assign rs1_used = (ID_SRCA_SEL == SRCA_RS1) || (ID_SRCA_SEL == SRCA_RSV);
  assign rs2_used = !ID_SRCB_SEL || ID_MEM_WRITE;

  always_comb begin
    load_use = 1'b0;
    if (ID_VALID && ex_valid_reg && ex_mem_read_reg && (ex_rd_addr_reg != 5'd0)) begin
      if (rs1_used && (ex_rd_addr_reg == ID_RS1_ADDR)) load_use = 1'b1;
      if (rs2_used && (ex_rd_addr_reg == ID_RS2_ADDR)) load_use = 1'b1;
    end
  end

  assign ID_STALL    = load_use;
  assign load_bubble = FLUSH || load_use || !ID_VALID;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      // The register file is written on the same edge we read it, so a
      // matching WB write must be taken directly.
      always_comb begin
        src_capture[gi] = id_src_data[gi];
        if (WB_REG_WRITE && (WB_RD_ADDR != 5'd0) && (WB_RD_ADDR == id_src_addr[gi]))
          src_capture[gi] = WB_DATA;
      end

      always_ff @(posedge CLK) begin
        if (RST || load_bubble) begin
          src_addr_reg[gi] <= 5'd0;
          src_data_reg[gi] <= '0;
        end else begin
          src_addr_reg[gi] <= id_src_addr[gi];
          src_data_reg[gi] <= src_capture[gi];
        end
      end

      // MEM is younger than WB, so it wins when both target the same register.
      always_comb begin
        src_fwd[gi] = src_data_reg[gi];
        if (MEM_REG_WRITE && (MEM_RD_ADDR != 5'd0) && (MEM_RD_ADDR == src_addr_reg[gi]))
          src_fwd[gi] = MEM_ALU_RESULT;
        else if (WB_REG_WRITE && (WB_RD_ADDR != 5'd0) && (WB_RD_ADDR == src_addr_reg[gi]))
          src_fwd[gi] = WB_DATA;
      end
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST || load_bubble) begin
      ex_valid_reg     <= 1'b0;
      ex_pc_reg        <= '0;
      ex_rd_addr_reg   <= 5'd0;
      ex_reg_write_reg <= 1'b0;
      ex_mem_read_reg  <= 1'b0;
      ex_mem_write_reg <= 1'b0;
      alu_fun_reg      <= 4'd0;
      imm_reg          <= '0;
      srca_sel_reg     <= 2'd0;
      srcb_sel_reg     <= 1'b0;
    end else begin
      ex_valid_reg     <= 1'b1;
      ex_pc_reg        <= ID_PC;
      ex_rd_addr_reg   <= ID_RD_ADDR;
      ex_reg_write_reg <= ID_REG_WRITE;
      ex_mem_read_reg  <= ID_MEM_READ;
      ex_mem_write_reg <= ID_MEM_WRITE;
      alu_fun_reg      <= ID_ALU_FUN;
      imm_reg          <= ID_IMM;
      srca_sel_reg     <= ID_SRCA_SEL;
      srcb_sel_reg     <= ID_SRCB_SEL;
    end
  end

  always_comb begin
    case (srca_sel_reg)
      SRCA_IMM: ALU_A = imm_reg;
      SRCA_PC:  ALU_A = ex_pc_reg;
      default:  ALU_A = src_fwd[0];
    endcase
  end

  assign ALU_B        = srcb_sel_reg ? imm_reg : src_fwd[1];
  assign EX_RS2_DATA  = src_fwd[1];
  assign EX_VALID     = ex_valid_reg;
  assign ALU_FUN      = alu_fun_reg;
  assign EX_PC        = ex_pc_reg;
  assign EX_RD_ADDR   = ex_rd_addr_reg;
  assign EX_REG_WRITE = ex_reg_write_reg;
  assign EX_MEM_READ  = ex_mem_read_reg;
  assign EX_MEM_WRITE = ex_mem_write_reg;

endmodule

// File: tb/tb_otter_id_ex_stage.sv
// Directed bench for otter_id_ex_stage: forwarding, x0 guard, load-use stall,
// flush, write-through, operand select and reset behaviour.
module tb_otter_id_ex_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ID_VALID;
  logic [31:0] ID_PC;
  logic [4:0]  ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR;
  logic [31:0] ID_RS1_DATA, ID_RS2_DATA, ID_IMM;
  logic [3:0]  ID_ALU_FUN;
  logic [1:0]  ID_SRCA_SEL;
  logic        ID_SRCB_SEL;
  logic        ID_REG_WRITE, ID_MEM_READ, ID_MEM_WRITE;
  logic        FLUSH;
  logic [4:0]  MEM_RD_ADDR;
  logic        MEM_REG_WRITE;
  logic [31:0] MEM_ALU_RESULT;
  logic [4:0]  WB_RD_ADDR;
  logic        WB_REG_WRITE;
  logic [31:0] WB_DATA;
  logic        ID_STALL, EX_VALID;
  logic [31:0] ALU_A, ALU_B, EX_RS2_DATA, EX_PC;
  logic [3:0]  ALU_FUN;
  logic [4:0]  EX_RD_ADDR;
  logic        EX_REG_WRITE, EX_MEM_READ, EX_MEM_WRITE;

  int n_checks = 0;
  int n_fails  = 0;

  otter_id_ex_stage #(.XLEN(32)) dut (
    .CLK(CLK), .RST(RST), .ID_VALID(ID_VALID), .ID_PC(ID_PC),
    .ID_RS1_ADDR(ID_RS1_ADDR), .ID_RS2_ADDR(ID_RS2_ADDR), .ID_RD_ADDR(ID_RD_ADDR),
    .ID_RS1_DATA(ID_RS1_DATA), .ID_RS2_DATA(ID_RS2_DATA), .ID_IMM(ID_IMM),
    .ID_ALU_FUN(ID_ALU_FUN), .ID_SRCA_SEL(ID_SRCA_SEL), .ID_SRCB_SEL(ID_SRCB_SEL),
    .ID_REG_WRITE(ID_REG_WRITE), .ID_MEM_READ(ID_MEM_READ), .ID_MEM_WRITE(ID_MEM_WRITE),
    .FLUSH(FLUSH), .MEM_RD_ADDR(MEM_RD_ADDR), .MEM_REG_WRITE(MEM_REG_WRITE),
    .MEM_ALU_RESULT(MEM_ALU_RESULT), .WB_RD_ADDR(WB_RD_ADDR), .WB_REG_WRITE(WB_REG_WRITE),
    .WB_DATA(WB_DATA), .ID_STALL(ID_STALL), .EX_VALID(EX_VALID), .ALU_A(ALU_A),
    .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .EX_RS2_DATA(EX_RS2_DATA), .EX_PC(EX_PC),
    .EX_RD_ADDR(EX_RD_ADDR), .EX_REG_WRITE(EX_REG_WRITE), .EX_MEM_READ(EX_MEM_READ),
    .EX_MEM_WRITE(EX_MEM_WRITE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] rd, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] imm, input logic [3:0] fun,
                        input logic [1:0] sa, input logic sb, input logic rw,
                        input logic mr, input logic mw);
    ID_VALID = v; ID_PC = pc; ID_RS1_ADDR = r1; ID_RS2_ADDR = r2; ID_RD_ADDR = rd;
    ID_RS1_DATA = d1; ID_RS2_DATA = d2; ID_IMM = imm; ID_ALU_FUN = fun;
    ID_SRCA_SEL = sa; ID_SRCB_SEL = sb; ID_REG_WRITE = rw; ID_MEM_READ = mr;
    ID_MEM_WRITE = mw;
  endtask

  task automatic set_mem(input logic [4:0] a, input logic we, input logic [31:0] d);
    MEM_RD_ADDR = a; MEM_REG_WRITE = we; MEM_ALU_RESULT = d;
  endtask

  task automatic set_wb(input logic [4:0] a, input logic we, input logic [31:0] d);
    WB_RD_ADDR = a; WB_REG_WRITE = we; WB_DATA = d;
  endtask

  task automatic set_lw_x7();
    set_id(1'b1, 32'h128, 5'd1, 5'd0, 5'd7, 32'h1000, 32'h0, 32'd4, 4'h0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    RST = 1'b1; FLUSH = 1'b0;
    set_mem(5'd0, 1'b0, 32'h0);
    set_wb(5'd0, 1'b0, 32'h0);
    set_id(1'b1, 32'h40, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 4'h5, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset held two cycles with a valid ID instruction
    tick(); tick(); settle();
    $display("step reset");
    chk("rst_ex_valid", {31'd0, EX_VALID}, 32'd0);
    chk("rst_alu_fun", {28'd0, ALU_FUN}, 32'd0);
    chk("rst_alu_a", ALU_A, 32'h0);
    chk("rst_alu_b", ALU_B, 32'h0);
    chk("rst_stall", {31'd0, ID_STALL}, 32'd0);
    chk("rst_reg_write", {31'd0, EX_REG_WRITE}, 32'd0);

    // add x6,x5,x5 with MEM writing x5
    RST = 1'b0;
    set_id(1'b1, 32'h104, 5'd5, 5'd5, 5'd6, 32'h111, 32'h111, 32'h0, 4'h0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    set_mem(5'd5, 1'b1, 32'h10); settle();
    $display("step mem_forward");
    chk("memfwd_alu_a", ALU_A, 32'h10);
    chk("memfwd_alu_b", ALU_B, 32'h10);
    chk("memfwd_rs2", EX_RS2_DATA, 32'h10);
    chk("memfwd_valid", {31'd0, EX_VALID}, 32'd1);
    chk("memfwd_rd", {27'd0, EX_RD_ADDR}, 32'd6);
    chk("memfwd_pc", EX_PC, 32'h104);
    chk("memfwd_regwrite", {31'd0, EX_REG_WRITE}, 32'd1);
    set_mem(5'd5, 1'b0, 32'h10); settle();
    chk("nofwd_alu_a", ALU_A, 32'h111);

    // MEM and WB both write x5
    set_mem(5'd5, 1'b1, 32'hAAAA); set_wb(5'd5, 1'b1, 32'h5555); settle();
    $display("step mem_over_wb");
    chk("mem_over_wb_a", ALU_A, 32'hAAAA);
    set_mem(5'd5, 1'b0, 32'hAAAA); settle();
    chk("wbfwd_a", ALU_A, 32'h5555);
    chk("wbfwd_b", ALU_B, 32'h5555);

    // Instruction reading x0 while MEM/WB claim to write x0
    set_mem(5'd0, 1'b0, 32'h0); set_wb(5'd0, 1'b0, 32'h0);
    set_id(1'b1, 32'h108, 5'd0, 5'd0, 5'd10, 32'h0, 32'h0, 32'h0, 4'h3, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    set_mem(5'd0, 1'b1, 32'hFFFFFFFF); set_wb(5'd0, 1'b1, 32'hDEADBEEF); settle();
    $display("step x0_guard");
    chk("x0_alu_a", ALU_A, 32'h0);
    chk("x0_alu_b", ALU_B, 32'h0);
    chk("x0_alu_fun", {28'd0, ALU_FUN}, 32'd3);

    // lw x7,4(x1) then add x8,x7,x1
    set_mem(5'd0, 1'b0, 32'h0); set_wb(5'd0, 1'b0, 32'h0);
    set_id(1'b1, 32'h10C, 5'd1, 5'd0, 5'd7, 32'h1000, 32'h0, 32'd4, 4'h0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 32'h110, 5'd7, 5'd1, 5'd8, 32'h999, 32'h22, 32'h0, 4'h0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    $display("step load_use_detect");
    chk("lu_stall", {31'd0, ID_STALL}, 32'd1);
    chk("lu_lw_alu_a", ALU_A, 32'h1000);
    chk("lu_lw_alu_b", ALU_B, 32'd4);
    chk("lu_lw_memread", {31'd0, EX_MEM_READ}, 32'd1);
    tick();
    set_mem(5'd7, 1'b1, 32'h1004); settle();
    $display("step load_use_bubble");
    chk("lu_bubble_valid", {31'd0, EX_VALID}, 32'd0);
    chk("lu_bubble_regwrite", {31'd0, EX_REG_WRITE}, 32'd0);
    chk("lu_stall_drop", {31'd0, ID_STALL}, 32'd0);
    tick();
    set_mem(5'd0, 1'b0, 32'h0); set_wb(5'd7, 1'b1, 32'hCAFE); settle();
    $display("step load_use_resume");
    chk("lu_add_valid", {31'd0, EX_VALID}, 32'd1);
    chk("lu_add_alu_a", ALU_A, 32'hCAFE);
    chk("lu_add_alu_b", ALU_B, 32'h22);
    chk("lu_add_rd", {27'd0, EX_RD_ADDR}, 32'd8);
    chk("lu_add_stall", {31'd0, ID_STALL}, 32'd0);

    // Flush of a valid instruction
    set_wb(5'd0, 1'b0, 32'h0);
    set_id(1'b1, 32'h114, 5'd2, 5'd3, 5'd11, 32'h5, 32'h6, 32'h0, 4'h2, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0; settle();
    $display("step flush");
    chk("flush_valid", {31'd0, EX_VALID}, 32'd0);
    chk("flush_regwrite", {31'd0, EX_REG_WRITE}, 32'd0);
    chk("flush_alu_fun", {28'd0, ALU_FUN}, 32'd0);

    // WB writes x9 on the capture edge
    set_id(1'b1, 32'h118, 5'd9, 5'd9, 5'd12, 32'h0, 32'h0, 32'h0, 4'h1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    set_wb(5'd9, 1'b1, 32'h1234);
    tick();
    set_wb(5'd0, 1'b0, 32'h0); settle();
    $display("step write_through");
    chk("wt_alu_a", ALU_A, 32'h1234);
    chk("wt_rs2", EX_RS2_DATA, 32'h1234);
    chk("wt_alu_fun", {28'd0, ALU_FUN}, 32'd1);

    // lui / auipc / reserved select
    set_id(1'b1, 32'h11C, 5'd0, 5'd0, 5'd13, 32'h0, 32'h0, 32'hABCDE000, 4'h0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); settle();
    $display("step lui");
    chk("lui_alu_a", ALU_A, 32'hABCDE000);
    set_id(1'b1, 32'h100, 5'd0, 5'd0, 5'd14, 32'h0, 32'h0, 32'h2000, 4'h0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); settle();
    $display("step auipc");
    chk("auipc_alu_a", ALU_A, 32'h100);
    chk("auipc_alu_b", ALU_B, 32'h2000);
    set_id(1'b1, 32'h120, 5'd4, 5'd0, 5'd15, 32'h77, 32'h0, 32'h5, 4'h0, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); settle();
    $display("step srca_reserved");
    chk("sel3_alu_a", ALU_A, 32'h77);

    // ID_VALID low loads a bubble
    set_id(1'b0, 32'h124, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, 4'h7, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); settle();
    $display("step id_invalid");
    chk("inv_valid", {31'd0, EX_VALID}, 32'd0);
    chk("inv_regwrite", {31'd0, EX_REG_WRITE}, 32'd0);
    chk("inv_alu_fun", {28'd0, ALU_FUN}, 32'd0);

    // Source-use qualification against a load of x7
    set_lw_x7();
    tick();
    set_id(1'b1, 32'h12C, 5'd1, 5'd7, 5'd0, 32'h50, 32'h60, 32'd8, 4'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    settle();
    $display("step use_qualify");
    chk("store_rs2_stall", {31'd0, ID_STALL}, 32'd1);
    set_id(1'b1, 32'h12C, 5'd1, 5'd7, 5'd16, 32'h50, 32'h60, 32'd8, 4'h0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    chk("imm_rs2_nostall", {31'd0, ID_STALL}, 32'd0);
    set_id(1'b1, 32'h12C, 5'd7, 5'd2, 5'd16, 32'h50, 32'h60, 32'd8, 4'h0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    chk("pc_rs1_nostall", {31'd0, ID_STALL}, 32'd0);

    // Flush together with stall: one bubble, then the instruction enters
    set_id(1'b1, 32'h130, 5'd7, 5'd2, 5'd16, 32'h50, 32'h60, 32'd0, 4'h0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    FLUSH = 1'b1; settle();
    $display("step flush_and_stall");
    chk("fs_stall", {31'd0, ID_STALL}, 32'd1);
    tick();
    FLUSH = 1'b0; settle();
    chk("fs_bubble_valid", {31'd0, EX_VALID}, 32'd0);
    chk("fs_stall_drop", {31'd0, ID_STALL}, 32'd0);
    tick(); settle();
    chk("fs_next_valid", {31'd0, EX_VALID}, 32'd1);
    chk("fs_next_rd", {27'd0, EX_RD_ADDR}, 32'd16);

    // Reset while a stall is pending
    set_lw_x7();
    tick();
    set_id(1'b1, 32'h134, 5'd7, 5'd2, 5'd17, 32'h50, 32'h60, 32'd0, 4'h0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    $display("step reset_mid_stall");
    chk("rms_stall_before", {31'd0, ID_STALL}, 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0; settle();
    chk("rms_stall_after", {31'd0, ID_STALL}, 32'd0);
    chk("rms_valid", {31'd0, EX_VALID}, 32'd0);
    chk("rms_memread", {31'd0, EX_MEM_READ}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/otter_id_ex_stage.md
# otter_id_ex_stage

ID/EX pipeline stage of the pipelined OTTER core, directly upstream of the ALU. It registers decoded instruction fields once per cycle and selects the ALU operands from register data, immediate or PC. It resolves data hazards by forwarding from the MEM and WB stages, and inserts a one-cycle bubble on a load-use hazard. It drives ALU_A, ALU_B and ALU_FUN straight into the ALU, and passes control and store data on to the EX/MEM register.

## Interface
- XLEN, 32, datapath width
- CLK  in  1  core clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- ID_VALID  in  1  decode stage holds a real instruction
- ID_PC  in  XLEN  PC of decoded instruction
- ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR  in  5 each  register specifiers
- ID_RS1_DATA, ID_RS2_DATA  in  XLEN  register-file read data
- ID_IMM  in  XLEN  sign-extended/formatted immediate
- ID_ALU_FUN  in  4  ALU operation code, passed unchanged
- ID_SRCA_SEL  in  2  0=rs1, 1=imm (lui copy), 2=PC (auipc), 3=reserved, treated as 0
- ID_SRCB_SEL  in  1  0=rs2, 1=imm
- ID_REG_WRITE, ID_MEM_READ, ID_MEM_WRITE  in  1 each  control bits
- FLUSH  in  1  taken branch/jump resolved; squash instruction entering EX
- MEM_RD_ADDR  in  5, MEM_REG_WRITE  in  1, MEM_ALU_RESULT  in  XLEN  EX/MEM forwarding source
- WB_RD_ADDR  in  5, WB_REG_WRITE  in  1, WB_DATA  in  XLEN  MEM/WB forwarding source, also the register-file write port
- ID_STALL  out  1  hold PC and IF/ID this cycle (combinational)
- EX_VALID  out  1  EX holds a real instruction
- ALU_A, ALU_B  out  XLEN  forwarded, selected ALU operands
- ALU_FUN  out  4  registered ALU operation
- EX_RS2_DATA  out  XLEN  forwarded rs2 value (store data)
- EX_PC  out  XLEN; EX_RD_ADDR  out  5; EX_REG_WRITE, EX_MEM_READ, EX_MEM_WRITE  out  1 each

## Operation
- Stage register: on each edge, load the ID fields into EX, or load a bubble.
- A bubble sets EX_VALID, EX_REG_WRITE, EX_MEM_READ and EX_MEM_WRITE to 0, and every other field to 0 (ALU_FUN=0 = add).
- Bubble loaded when FLUSH=1, ID_STALL=1, or ID_VALID=0. FLUSH and stall together still give exactly one bubble.
- WB write-through at capture: if WB_REG_WRITE=1, WB_RD_ADDR≠0 and WB_RD_ADDR==ID_RS1_ADDR, latch WB_DATA instead of ID_RS1_DATA. rs2 works the same way.
- rs1 is "used" when ID_SRCA_SEL∈{0,3}. rs2 is "used" when ID_SRCB_SEL=0 or ID_MEM_WRITE=1.
- Load-use hazard: ID_STALL=1 when all of the following hold:
  - ID_VALID=1, EX_VALID=1 and EX_MEM_READ=1;
  - EX_RD_ADDR≠0;
  - EX_RD_ADDR equals a used source address.
  - ID_STALL is not suppressed by FLUSH. Upstream gives FLUSH priority.
- Forwarding for the registered rs1 (rs2 identical):
  - If MEM_REG_WRITE=1, MEM_RD_ADDR≠0 and addresses match → MEM_ALU_RESULT.
  - Else if WB_REG_WRITE=1, WB_RD_ADDR≠0 and addresses match → WB_DATA.
  - Else use the latched value. MEM has priority over WB.
- Register x0 is never forwarded and always reads as latched (0 from the register file).
- ALU_A: SRCA_SEL 0/3 → forwarded rs1; 1 → imm; 2 → PC.
- ALU_B: SRCB_SEL 0 → forwarded rs2; 1 → imm.
- EX_RS2_DATA is always the forwarded rs2, regardless of SRCB_SEL.

## Timing
- Latency: ID fields appear on EX outputs one cycle after capture.
- ALU_A, ALU_B, EX_RS2_DATA and ID_STALL are combinational within the cycle. The registered state is EX_* plus the latched rs1/rs2 data, imm, PC and select fields.
- Load-use costs exactly one bubble. Next cycle, the load is in MEM/WB, EX_MEM_READ=0, and ID_STALL drops.
- Reset: all EX registers clear to 0 on the first edge with RST=1, so EX_VALID=0 and ALU_FUN=0.
- ID_STALL=0 while EX_VALID=0, i.e. from the first edge with RST=1 onward. Reset mid-stall clears the stall on that edge.
- No back-to-back stall from the same load.

## Test plan
- Reset: RST=1 for 2 cycles with ID_VALID=1 → EX_VALID=0, ALU_FUN=0, ALU_A=ALU_B=0, ID_STALL=0.
- MEM forward: EX/MEM writes x5=0x10; next instruction add x6,x5,x5 → ALU_A=ALU_B=0x10.
- MEM over WB: MEM x5=0xAAAA and WB x5=0x5555 → ALU_A=0xAAAA.
- x0 guard: MEM_RD_ADDR=0, MEM_REG_WRITE=1, MEM_ALU_RESULT=0xFFFFFFFF, instruction reads x0 → ALU_A=0.
- Load-use: lw x7 then add x8,x7,x1 → ID_STALL=1 for one cycle, then one bubble (EX_VALID=0). Next cycle the add is in EX and ALU_A=WB_DATA.
- Flush and write-through:
  - FLUSH=1 with a valid ID → EX_VALID=0 and EX_REG_WRITE=0 next cycle.
  - Capture while WB writes x9=0x1234 and the ID instruction reads x9 → latched rs1=0x1234.
- lui/auipc: SRCA_SEL=1, imm=0xABCDE000 → ALU_A=0xABCDE000. SRCA_SEL=2, PC=0x100 → ALU_A=0x100.
